// File: rtl/mc_cpu_core.sv
// rtl/mc_cpu_core.sv - multicycle MIPS-subset core with handshaked instruction/data memories
// Optional single-step fetch gate is enabled by defining MC_CPU_SINGLE_STEP_EN.
module mc_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 8,
  localparam int RW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef MC_CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [RW-1:0]     dbg_ra,
  output logic [DATA_W-1:0] dbg_rd,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              retire,
  output logic              illegal
);

  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_q, b_q, alu_out, mdr, alu_res, wr_data, imm_d;
  logic [DATA_W-1:0] regs [NREGS];
  logic              illegal_q, is_r, legal, fetch_go;
  logic [5:0]        op, funct;
  logic [RW-1:0]     rs, rt, rd, wr_idx;
  logic [31:0]       imm_ext, alu_ext;
  logic [ADDR_W-1:0] imm_a;
  logic              unused_bits;

  assign op      = ir[31:26];
  assign funct   = ir[5:0];
  assign rs      = ir[21 +: RW];
  assign rt      = ir[16 +: RW];
  assign rd      = ir[11 +: RW];
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};
  assign imm_d   = imm_ext[DATA_W-1:0];
  assign imm_a   = imm_ext[ADDR_W-1:0];
  assign alu_ext = 32'(alu_out);
  assign unused_bits = ^{ir, imm_ext, alu_ext};

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign state      = state_q;
  assign illegal    = illegal_q;
  assign dmem_addr  = alu_ext[ADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign dbg_rd     = (dbg_ra == '0) ? '0 : regs[dbg_ra];

`ifdef MC_CPU_SINGLE_STEP_EN
  // A rising edge on step arms exactly one fetch; holding step high re-arms nothing.
  logic step_q, armed;
  assign fetch_go = armed;
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      step_q <= step;
      if (step && !step_q) armed <= 1'b1;
      else if (state_q == FETCH && imem_valid && armed) armed <= 1'b0;
    end
  end
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    is_r  = (op == OP_RTYPE);
    legal = 1'b0;
    if (is_r) legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    else      legal = op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  end

  always_comb begin
    alu_res = a_q + imm_d;
    if (is_r) begin
      case (funct)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  always_comb begin
    wr_idx  = is_r ? rd : rt;
    wr_data = (op == OP_LW) ? mdr : alu_out;
  end

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = fetch_go;
        if (fetch_go && imem_valid) state_d = DECODE;
      end
      DECODE: begin
        if (op == OP_J || !legal) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op == OP_BEQ) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_SW);
        if (dmem_ready) begin
          retire  = (op == OP_SW);
          state_d = (op == OP_SW) ? FETCH : WB;
        end
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir        <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        FETCH: begin
          if (fetch_go && imem_valid) begin
            ir   <= imem_rdata;
            pc_q <= pc_q + ADDR_W'(1);
          end
        end
        DECODE: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
          if (op == OP_J) pc_q <= ir[ADDR_W-1:0];
          if (!legal) illegal_q <= 1'b1;
        end
        EXEC: begin
          alu_out <= alu_res;
          // pc_q already points past the branch, so this lands on PC+1+imm.
          if (op == OP_BEQ && a_q == b_q) pc_q <= pc_q + imm_a;
        end
        MEM: if (dmem_ready && op == OP_LW) mdr <= dmem_rdata;
        WB: if (wr_idx != '0) regs[wr_idx] <= wr_data;
        default: ;
      endcase
    end
  end

endmodule
